// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the register file's single synchronous write port between two
//   writeback requesters.
//     Requester 0: single-cycle datapath writeback, high priority.
//     Requester 1: multi-cycle unit (load/mul), low priority.
//   Priority is fixed. A starvation guard forces one requester-1 grant after
//   requester 1 has been refused STARVE_LIMIT consecutive cycles.
//   The accepted beat appears on rf_wr_* one cycle after acceptance.
//   A write to x0 is accepted, but the beat leaves rf_wr_en low.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   req0_valid/addr/data    requester 0 write request
//   req0_ready              requester 0 accepted this cycle (combinational)
//   req1_valid/addr/data    requester 1 write request
//   req1_ready              requester 1 accepted this cycle (combinational)
//   rf_wr_en/addr/data      register-file write port (registered)
//   grant_id                source of the current rf_wr_* beat (registered)
//   starved                 forced-grant state active
module rf_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [4:0]            req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [4:0]            req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_wr_en,
  output logic [4:0]            rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  grant_id,
  output logic                  starved
);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE1 = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_t                state_q, state_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  grant_id_q, grant_id_d;
  logic                  grant0_s, grant1_s;

  // Acceptance decision from the current arbitration state.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        grant0_s = req0_valid;
        grant1_s = req1_valid && !req0_valid;
      end
      ST_FORCE1: begin
        grant0_s = 1'b0;
        grant1_s = req1_valid;
      end
      default: begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    endcase
  end

  // Nothing is accepted while reset is held, even with valids high.
  assign req0_ready = grant0_s && !reset;
  assign req1_ready = grant1_s && !reset;

  // Starvation tracking and state transitions.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (req1_valid && !grant1_s) begin
          // The refusal that reaches the limit moves straight to FORCE1.
          if (starve_cnt_q == LIMIT_M1) begin
            state_d      = ST_FORCE1;
            starve_cnt_d = LIMIT;
          end else if (starve_cnt_q >= LIMIT) begin
            starve_cnt_d = LIMIT;
          end else begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else begin
          starve_cnt_d = 4'd0;
        end
      end
      ST_FORCE1: begin
        // Requester 1 is either accepted now or has withdrawn: exit
        // after exactly one cycle.
        state_d      = ST_NORMAL;
        starve_cnt_d = 4'd0;
      end
      default: begin
        state_d      = ST_NORMAL;
        starve_cnt_d = 4'd0;
      end
    endcase
  end

  // Next write beat: the accepted request's fields; otherwise hold
  // address/data/source and drop the enable.
  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    if (grant0_s) begin
      wr_en_d    = (req0_addr != 5'd0);
      wr_addr_d  = req0_addr;
      wr_data_d  = req0_data;
      grant_id_d = 1'b0;
    end else if (grant1_s) begin
      wr_en_d    = (req1_addr != 5'd0);
      wr_addr_d  = req1_addr;
      wr_data_d  = req1_data;
      grant_id_d = 1'b1;
    end else begin
      wr_en_d    = 1'b0;
    end
  end

  // State, counter and write-port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= 4'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= '0;
      grant_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign grant_id   = grant_id_q;
  assign starved    = (state_q == ST_FORCE1);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [4:0]    req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          grant_id;
  logic          starved;

  rf_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .grant_id   (grant_id),
    .starved    (starved)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: number of consecutive refusals of requester 1 and the
  // beat currently expected on the write port.
  int            refusals;
  logic          exp_en;
  logic [4:0]    exp_addr;
  logic [DW-1:0] exp_data;
  logic          exp_gid;
  logic          samp_r0, samp_r1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    refusals = 0;
    exp_en   = 1'b0;
    exp_addr = 5'd0;
    exp_data = '0;
    exp_gid  = 1'b0;
  endtask

  // Called just after a falling edge: drive inputs, compare everything
  // against the model, advance the model across the coming rising edge.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [DW-1:0] d1);
    logic forced, e_r0, e_r1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    forced = (refusals >= LIMIT);
    e_r0   = v0 && !forced;
    e_r1   = forced ? v1 : (v1 && !v0);
    chk("req0_ready", 64'(req0_ready), 64'(e_r0));
    chk("req1_ready", 64'(req1_ready), 64'(e_r1));
    chk("starved",    64'(starved),    64'(forced));
    chk("rf_wr_en",   64'(rf_wr_en),   64'(exp_en));
    chk("rf_wr_addr", 64'(rf_wr_addr), 64'(exp_addr));
    chk("rf_wr_data", 64'(rf_wr_data), 64'(exp_data));
    chk("grant_id",   64'(grant_id),   64'(exp_gid));
    samp_r0 = req0_ready;
    samp_r1 = req1_ready;
    if (e_r0) begin
      exp_en = (a0 != 5'd0); exp_addr = a0; exp_data = d0; exp_gid = 1'b0;
    end else if (e_r1) begin
      exp_en = (a1 != 5'd0); exp_addr = a1; exp_data = d1; exp_gid = 1'b1;
    end else begin
      exp_en = 1'b0;
    end
    if (v1 && !e_r1) refusals++;
    else refusals = 0;
    @(negedge clk);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  logic [9:0]    pat10;
  logic [4:0]    pat5;
  logic          c_v0, c_v1;
  logic [4:0]    c_a0, c_a1;
  logic [DW-1:0] c_d0, c_d1;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11111111;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22222222;
    model_reset();
    samp_r0 = 1'b0;
    samp_r1 = 1'b0;

    // Reset held with both valids high.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_wr_en",      64'(rf_wr_en),   64'd0);
    chk("rst_starved",    64'(starved),    64'd0);
    chk("rst_addr",       64'(rf_wr_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222);
    chk("first_grant_r0", 64'(samp_r0), 64'd1);
    chk("first_grant_r1", 64'(samp_r1), 64'd0);

    // Lone requester 0 write.
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    chk("beef_ready", 64'(samp_r0), 64'd1);
    #1;
    chk("beef_en",   64'(rf_wr_en),   64'd1);
    chk("beef_addr", 64'(rf_wr_addr), 64'd5);
    chk("beef_data", 64'(rf_wr_data), 64'hDEADBEEF);
    chk("beef_gid",  64'(grant_id),   64'd0);

    // Both valid continuously: requester 1 gets every fifth slot.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'(i + 1), 32'(i), 1'b1, 5'd9, 32'hABCD0000);
      pat10[i] = samp_r1;
    end
    chk("starve_pattern", 64'(pat10), 64'(10'b10000_10000));

    // Requester 1 alone writing x0.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    chk("x0_ready", 64'(samp_r1), 64'd1);
    #1;
    chk("x0_en",  64'(rf_wr_en), 64'd0);
    chk("x0_gid", 64'(grant_id), 64'd1);
    chk("x0_data", 64'(rf_wr_data), 64'h1234);

    // Three refusals, a one-cycle withdrawal, then a full new wait.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8);
    step(1'b1, 5'd7, 32'h7, 1'b0, 5'd8, 32'h8);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8);
      pat5[i] = samp_r1;
    end
    chk("withdraw_pattern", 64'(pat5), 64'(5'b10000));

    // Reset arriving while FORCE1 is active with a beat on the port.
    for (int i = 0; i < 4; i++) step(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
    #1;
    chk("pre_rst_starved", 64'(starved),  64'd1);
    chk("pre_rst_en",      64'(rf_wr_en), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_en",      64'(rf_wr_en),   64'd0);
    chk("mid_rst_starved", 64'(starved),    64'd0);
    chk("mid_rst_r1",      64'(req1_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
    chk("post_rst_r0", 64'(samp_r0), 64'd1);

    // Randomized traffic: valid held until accepted, occasional withdrawal
    // of requester 1.
    c_v0 = 1'b0; c_v1 = 1'b0;
    c_a0 = 5'd0; c_a1 = 5'd0; c_d0 = '0; c_d1 = '0;
    for (int i = 0; i < 3000; i++) begin
      step(c_v0, c_a0, c_d0, c_v1, c_a1, c_d1);
      if (samp_r0 || !c_v0) begin
        c_v0 = ($urandom_range(0, 3) != 0);
        c_a0 = rnd_addr();
        c_d0 = $urandom;
      end
      if (samp_r1 || !c_v1) begin
        c_v1 = ($urandom_range(0, 2) != 0);
        c_a1 = rnd_addr();
        c_d1 = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        c_v1 = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single synchronous write port between two writeback requesters.
  - Requester 0: main single-cycle datapath writeback, default high priority.
  - Requester 1: multi-cycle unit (load/mul), low priority.
- Fixed priority, with a starvation guard that forces a requester-1 grant after a bounded wait.
- Drives the register file's wr_en / wr_addr / wr_data from registers, one cycle after acceptance.

Parameters:
- DATA_WIDTH, 32, width of write data.
- STARVE_LIMIT, 4, consecutive cycles requester 1 may be refused before it is forced through (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  5  requester 0 destination register.
- req0_data  input  DATA_WIDTH  requester 0 write data.
- req0_ready  output  1  requester 0 accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  5  requester 1 destination register.
- req1_data  input  DATA_WIDTH  requester 1 write data.
- req1_ready  output  1  requester 1 accepted this cycle (combinational).
- rf_wr_en  output  1  register-file write enable (registered).
- rf_wr_addr  output  5  register-file write address (registered).
- rf_wr_data  output  DATA_WIDTH  register-file write data (registered).
- grant_id  output  1  source of the current rf_wr_* beat: 0 or 1 (registered).
- starved  output  1  high while the forced-grant state is active.

Behaviour:
- Reset, asynchronous on assertion, released synchronously to clk:
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0.
  - starve_cnt=0, state=NORMAL, starved=0.
- Handshake:
  - A transfer occurs when valid&&ready are both high at a clk rising edge.
  - Valid is held by the requester until accepted; addr/data must be stable while valid.
  - At most one transfer per cycle.
- State NORMAL:
  - req0_ready = req0_valid.
  - req1_ready = req1_valid && !req0_valid.
- State FORCE1:
  - req1_ready = req1_valid.
  - req0_ready = 0.
  - starved = 1.
- Starvation counter starve_cnt, 4 bits:
  - Increments when state==NORMAL and req1_valid && !req1_ready.
  - Clears when req1 is accepted or req1_valid==0.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - NORMAL->FORCE1 on the edge where starve_cnt==STARVE_LIMIT-1 and requester 1 is refused again.
  - FORCE1->NORMAL after the requester-1 transfer, or immediately if req1_valid drops; starve_cnt clears.
  - FORCE1 lasts exactly one grant.
- Write output, one cycle latency:
  - On the edge of a transfer: rf_wr_addr/rf_wr_data/grant_id <= the accepted requester's fields.
  - rf_wr_en <= 1 unless addr==0. A write to x0 is accepted (ready=1) but rf_wr_en stays 0.
  - With no transfer: rf_wr_en <= 0, addr/data/grant_id hold their previous values.
- Simultaneous valids in NORMAL: requester 0 wins; requester 1 waits and counts.
- Same destination register from both requesters on consecutive cycles: writes are applied in grant order, and the later grant wins. No hazard logic is in this block.
- Reset mid-FORCE1: state returns to NORMAL and any in-flight output beat is dropped (rf_wr_en=0).

Test Plan:
- Reset with both valids high -> during reset rf_wr_en=0, both readys 0; first edge after release grants req0.
- req0_valid=1 addr=5 data=0xDEADBEEF alone -> req0_ready=1 same cycle; next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF, grant_id=0.
- req0 and req1 both valid continuously, STARVE_LIMIT=4 -> req0 granted cycles 0-3; cycle 4 starved=1, req1_ready=1, req0_ready=0; cycle 5 back to req0; pattern repeats every 5 cycles.
- req1_valid alone, addr=0 data=0x1234 -> req1_ready=1; next cycle rf_wr_en=0, grant_id=1.
- req1 starved 3 cycles then req1_valid dropped for 1 cycle -> starve_cnt clears; req1 reasserted then needs 4 more refusals before forced grant.
- Assert reset while in FORCE1 with a beat in flight -> rf_wr_en=0 immediately (asynchronous); starved=0; state NORMAL after release.
